param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 115 +++++++++++
 tb/tb_param_sync_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with registered read data, occupancy count and almost/full/empty status.
// Latency: a read accepted on edge N presents data on buf_out with rd_valid=1 until edge N+1.
// Backpressure: writes to a full FIFO are dropped (overflow) unless a read is accepted on the same edge.
//
// Ports:
//   clk, rst_n (async active-low), flush (sync clear of contents)
//   wr_en/buf_in write side; rd_en/buf_out/rd_valid read side
//   buf_full, buf_empty, almost_full, almost_empty, fifo_counter: status from registered state
//   overflow, underflow: error flags
// Build option: define FIFO_STICKY_ERR_EN to make overflow/underflow hold until flush or reset;
// otherwise they are one-cycle pulses.
module param_sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] buf_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] buf_out,
    output logic             rd_valid,
    output logic             buf_full,
    output logic             buf_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    fifo_counter,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic wr_acc;
    logic rd_acc;
    logic ovf_req;
    logic unf_req;

    // Status is decoded purely from the registered count.
    assign buf_full     = (fifo_counter == FULL_CNT);
    assign buf_empty    = (fifo_counter == '0);
    assign almost_full  = (fifo_counter >= AF_CNT);
    assign almost_empty = (fifo_counter <= AE_CNT);

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    // An empty FIFO never forwards write data straight to the read side.
    assign wr_acc  = !flush && wr_en && (!buf_full || rd_en);
    assign rd_acc  = !flush && rd_en && !buf_empty;
    assign ovf_req = !flush && wr_en && buf_full && !rd_en;
    assign unf_req = !flush && rd_en && buf_empty;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= buf_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
            buf_out      <= '0;
            rd_valid     <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
            rd_valid     <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr  <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                buf_out <= mem[rd_ptr];
            end
            if (wr_acc && !rd_acc) begin
                fifo_counter <= fifo_counter + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                fifo_counter <= fifo_counter - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
`ifdef FIFO_STICKY_ERR_EN
            overflow  <= flush ? 1'b0 : (overflow  | ovf_req);
            underflow <= flush ? 1'b0 : (underflow | unf_req);
`else
            overflow  <= ovf_req;
            underflow <= unf_req;
`endif
        end
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: DEPTH=16 instance (a) and DEPTH=5 instance (b).
// Latency: compares registered outputs on the falling edge after each driven rising edge.
// Backpressure: scoreboard queues hold expected read data in acceptance order.
module tb_param_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=16 instance
    logic       rst_a, fl_a, wr_a, rd_a;
    logic [7:0] din_a, dout_a;
    logic       rv_a, full_a, empty_a, af_a, ae_a, ov_a, un_a;
    logic [4:0] cnt_a;

    // DEPTH=5 instance
    logic       rst_b, fl_b, wr_b, rd_b;
    logic [7:0] din_b, dout_b;
    logic       rv_b, full_b, empty_b, af_b, ae_b, ov_b, un_b;
    logic [2:0] cnt_b;

    param_sync_fifo #(.WIDTH(8), .DEPTH(16)) u_a (
        .clk(clk), .rst_n(rst_a), .flush(fl_a), .wr_en(wr_a), .buf_in(din_a), .rd_en(rd_a),
        .buf_out(dout_a), .rd_valid(rv_a), .buf_full(full_a), .buf_empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .fifo_counter(cnt_a),
        .overflow(ov_a), .underflow(un_a)
    );

    param_sync_fifo #(.WIDTH(8), .DEPTH(5)) u_b (
        .clk(clk), .rst_n(rst_b), .flush(fl_b), .wr_en(wr_b), .buf_in(din_b), .rd_en(rd_b),
        .buf_out(dout_b), .rd_valid(rv_b), .buf_full(full_b), .buf_empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .fifo_counter(cnt_b),
        .overflow(ov_b), .underflow(un_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int         mcnt_a = 0;
    int         mcnt_b = 0;
    logic       erv_a = 1'b0;
    logic       erv_b = 1'b0;
    logic       mov_a = 1'b0;
    logic       mun_a = 1'b0;
    logic [7:0] exp_d;

    // Drive one cycle on instance a and advance the model; outputs settle by the falling edge.
    task automatic step_a(input logic w, input logic r, input logic f, input logic [7:0] d);
        logic ovc, unc, aw, ar;
        wr_a = w; rd_a = r; fl_a = f; din_a = d;
        ovc = !f && w && (mcnt_a == 16) && !r;
        unc = !f && r && (mcnt_a == 0);
`ifdef FIFO_STICKY_ERR_EN
        mov_a = f ? 1'b0 : (mov_a | ovc);
        mun_a = f ? 1'b0 : (mun_a | unc);
`else
        mov_a = ovc;
        mun_a = unc;
`endif
        if (f) begin
            mcnt_a = 0;
            q_a.delete();
            erv_a = 1'b0;
        end else begin
            ar = r && (mcnt_a != 0);
            aw = w && ((mcnt_a != 16) || r);
            if (aw) q_a.push_back(d);
            if (aw && !ar) mcnt_a++;
            if (ar && !aw) mcnt_a--;
            erv_a = ar;
        end
        @(posedge clk);
        @(negedge clk);
        wr_a = 1'b0; rd_a = 1'b0; fl_a = 1'b0;
    endtask

    task automatic step_b(input logic w, input logic r, input logic f, input logic [7:0] d);
        logic aw, ar;
        wr_b = w; rd_b = r; fl_b = f; din_b = d;
        if (f) begin
            mcnt_b = 0;
            q_b.delete();
            erv_b = 1'b0;
        end else begin
            ar = r && (mcnt_b != 0);
            aw = w && ((mcnt_b != 5) || r);
            if (aw) q_b.push_back(d);
            if (aw && !ar) mcnt_b++;
            if (ar && !aw) mcnt_b--;
            erv_b = ar;
        end
        @(posedge clk);
        @(negedge clk);
        wr_b = 1'b0; rd_b = 1'b0; fl_b = 1'b0;
    endtask

    task automatic test_reset;
        rst_a = 1'b0; rst_b = 1'b0;
        fl_a = 0; wr_a = 0; rd_a = 0; din_a = '0;
        fl_b = 0; wr_b = 0; rd_b = 0; din_b = '0;
        repeat (2) @(negedge clk);
        tests++; if (cnt_a !== 5'd0)  begin fails++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
        tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", empty_a); end
        tests++; if (full_a !== 1'b0)  begin fails++; $display("FAIL reset_full: got %b want 0", full_a); end
        tests++; if (af_a !== 1'b0)    begin fails++; $display("FAIL reset_af: got %b want 0", af_a); end
        tests++; if (ae_a !== 1'b1)    begin fails++; $display("FAIL reset_ae: got %b want 1", ae_a); end
        tests++; if (rv_a !== 1'b0)    begin fails++; $display("FAIL reset_rv: got %b want 0", rv_a); end
        tests++; if (dout_a !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", dout_a); end
        tests++; if ({ov_a, un_a} !== 2'b00) begin fails++; $display("FAIL reset_err: got %b want 00", {ov_a, un_a}); end
        tests++; if ({cnt_b, empty_b} !== 4'b0001) begin fails++; $display("FAIL reset_b: got cnt %0d empty %b want 0 1", cnt_b, empty_b); end
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill;
        for (int i = 0; i < 16; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 8'(i));
            tests++; if (af_a !== ((i + 1) >= 14)) begin fails++; $display("FAIL fill_af[%0d]: got %b want %b", i, af_a, ((i + 1) >= 14)); end
            tests++; if (cnt_a !== 5'(mcnt_a)) begin fails++; $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, cnt_a, mcnt_a); end
        end
        tests++; if (full_a !== 1'b1 || cnt_a !== 5'd16) begin fails++; $display("FAIL fill_full: got full %b cnt %0d want 1 16", full_a, cnt_a); end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 16; i++) begin
            step_a(1'b0, 1'b1, 1'b0, 8'h00);
            tests++; if (rv_a !== erv_a) begin fails++; $display("FAIL drain_rv[%0d]: got %b want %b", i, rv_a, erv_a); end
            if (erv_a) begin
                exp_d = q_a.pop_front();
                tests++; if (dout_a !== exp_d) begin fails++; $display("FAIL drain_dat[%0d]: got %h want %h", i, dout_a, exp_d); end
            end
        end
        tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL drain_empty: got %b want 1", empty_a); end
        step_a(1'b0, 1'b0, 1'b0, 8'h00);
        tests++; if (rv_a !== 1'b0 || dout_a !== 8'h0F) begin fails++; $display("FAIL drain_hold: got rv %b dout %h want 0 0f", rv_a, dout_a); end
    endtask

    task automatic test_full_rw;
        for (int i = 0; i < 16; i++) step_a(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        step_a(1'b1, 1'b1, 1'b0, 8'hAA);
        tests++; if (cnt_a !== 5'd16) begin fails++; $display("FAIL fullrw_cnt: got %0d want 16", cnt_a); end
        tests++; if (rv_a !== 1'b1) begin fails++; $display("FAIL fullrw_rv: got %b want 1", rv_a); end
        exp_d = q_a.pop_front();
        tests++; if (dout_a !== exp_d) begin fails++; $display("FAIL fullrw_first: got %h want %h", dout_a, exp_d); end
        for (int i = 0; i < 16; i++) begin
            step_a(1'b0, 1'b1, 1'b0, 8'h00);
            tests++; if (rv_a !== 1'b1) begin fails++; $display("FAIL fullrw_rv[%0d]: got %b want 1", i, rv_a); end
            exp_d = (q_a.size() != 0) ? q_a.pop_front() : 8'hXX;
            tests++; if (dout_a !== exp_d) begin fails++; $display("FAIL fullrw_dat[%0d]: got %h want %h", i, dout_a, exp_d); end
        end
        tests++; if (dout_a !== 8'hAA) begin fails++; $display("FAIL fullrw_last: got %h want aa", dout_a); end
    endtask

    task automatic test_empty_rw;
        step_a(1'b1, 1'b1, 1'b0, 8'h55);
        tests++; if (rv_a !== 1'b0 || cnt_a !== 5'd1) begin fails++; $display("FAIL emptyrw: got rv %b cnt %0d want 0 1", rv_a, cnt_a); end
        tests++; if (un_a !== mun_a) begin fails++; $display("FAIL emptyrw_un: got %b want %b", un_a, mun_a); end
        step_a(1'b0, 1'b1, 1'b0, 8'h00);
        exp_d = q_a.pop_front();
        tests++; if (rv_a !== 1'b1 || dout_a !== exp_d) begin fails++; $display("FAIL emptyrw_read: got rv %b dout %h want 1 %h", rv_a, dout_a, exp_d); end
    endtask

    task automatic test_errors;
        step_a(1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if ({ov_a, un_a} !== 2'b00 || cnt_a !== 5'd0) begin fails++; $display("FAIL flush_a: got err %b cnt %0d want 00 0", {ov_a, un_a}, cnt_a); end
        for (int i = 0; i < 16; i++) step_a(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        step_a(1'b1, 1'b0, 1'b0, 8'hEE);
        tests++; if (ov_a !== 1'b1 || cnt_a !== 5'd16) begin fails++; $display("FAIL ovf_set: got ov %b cnt %0d want 1 16", ov_a, cnt_a); end
        for (int i = 0; i < 2; i++) begin
            step_a(1'b0, 1'b0, 1'b0, 8'h00);
            tests++; if (ov_a !== mov_a) begin fails++; $display("FAIL ovf_after[%0d]: got %b want %b", i, ov_a, mov_a); end
        end
        for (int i = 0; i < 16; i++) begin
            step_a(1'b0, 1'b1, 1'b0, 8'h00);
            exp_d = q_a.pop_front();
            tests++; if (rv_a !== 1'b1 || dout_a !== exp_d) begin fails++; $display("FAIL ovf_contents[%0d]: got rv %b dout %h want 1 %h", i, rv_a, dout_a, exp_d); end
        end
        step_a(1'b0, 1'b1, 1'b0, 8'h00);
        tests++; if (un_a !== 1'b1 || rv_a !== 1'b0 || dout_a !== 8'h2F) begin fails++; $display("FAIL unf_set: got un %b rv %b dout %h want 1 0 2f", un_a, rv_a, dout_a); end
        step_a(1'b0, 1'b0, 1'b0, 8'h00);
        tests++; if (un_a !== mun_a || ov_a !== mov_a) begin fails++; $display("FAIL unf_after: got un %b ov %b want %b %b", un_a, ov_a, mun_a, mov_a); end
        step_a(1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if ({ov_a, un_a} !== 2'b00) begin fails++; $display("FAIL err_flush: got %b want 00", {ov_a, un_a}); end
    endtask

    task automatic test_wrap_reset;
        for (int i = 0; i < 3; i++) step_b(1'b1, 1'b0, 1'b0, 8'(8'h01 + i));
        for (int i = 0; i < 3; i++) begin
            step_b(1'b0, 1'b1, 1'b0, 8'h00);
            exp_d = q_b.pop_front();
            tests++; if (rv_b !== erv_b || dout_b !== exp_d) begin fails++; $display("FAIL wrap_rd[%0d]: got rv %b dout %h want %b %h", i, rv_b, dout_b, erv_b, exp_d); end
        end
        for (int i = 0; i < 5; i++) step_b(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        tests++; if (cnt_b !== 3'd5 || full_b !== 1'b1) begin fails++; $display("FAIL wrap_full: got cnt %0d full %b want 5 1", cnt_b, full_b); end
        step_b(1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if (cnt_b !== 3'd0 || empty_b !== 1'b1) begin fails++; $display("FAIL wrap_flush: got cnt %0d empty %b want 0 1", cnt_b, empty_b); end
        step_b(1'b1, 1'b0, 1'b0, 8'h50);
        step_b(1'b1, 1'b0, 1'b0, 8'h51);
        wr_b = 1'b1; din_b = 8'h52;
        #2 rst_b = 1'b0;
        #1;
        tests++; if (cnt_b !== 3'd0 || empty_b !== 1'b1 || rv_b !== 1'b0) begin fails++; $display("FAIL midreset: got cnt %0d empty %b rv %b want 0 1 0", cnt_b, empty_b, rv_b); end
        mcnt_b = 0; q_b.delete(); erv_b = 1'b0;
        @(negedge clk);
        wr_b = 1'b0;
        rst_b = 1'b1;
        @(negedge clk);
        step_b(1'b1, 1'b0, 1'b0, 8'h77);
        tests++; if (u_b.mem[0] !== 8'h77 || cnt_b !== 3'd1) begin fails++; $display("FAIL post_reset_wr: got mem0 %h cnt %0d want 77 1", u_b.mem[0], cnt_b); end
        step_b(1'b0, 1'b1, 1'b0, 8'h00);
        exp_d = q_b.pop_front();
        tests++; if (rv_b !== 1'b1 || dout_b !== exp_d) begin fails++; $display("FAIL post_reset_rd: got rv %b dout %h want 1 %h", rv_b, dout_b, exp_d); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_errors();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
